// File: rtl/map_port_arbiter.sv
// 32x32x2-bit tile map: a free combinational renderer read port plus a round-robin arbitrated RMW port and a level loader.
// Optional feature: define MAP_BRICK_ARMOR_EN so a HIT cracks a brick (1->3) before destroying it (3->0).
module map_port_arbiter #(
    parameter int NREQ  = 4,
    parameter int MAP_W = 25,
    parameter int MAP_H = 18
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic [4:0]        map_rd_x,
    input  logic [4:0]        map_rd_y,
    output logic [1:0]        map_tile,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [5*NREQ-1:0] req_x,
    input  logic [5*NREQ-1:0] req_y,
    input  logic [2*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [1:0]        rsp_tile,
    input  logic              load_start,
    output logic              busy,
    output logic              load_done
);
    localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    localparam logic [1:0] OP_HIT   = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [5:0] MAP_W6 = 6'(MAP_W);
    localparam logic [5:0] MAP_H6 = 6'(MAP_H);
    localparam logic [4:0] X_LAST = 5'(MAP_W - 1);
    localparam logic [4:0] Y_LAST = 5'(MAP_H - 1);

    logic [1:0]      tile_mem [0:1023];
    logic [0:0]      state;
    logic [9:0]      load_cnt;
    logic [RR_W-1:0] rr_ptr;

    function automatic logic in_map(input logic [4:0] x, input logic [4:0] y);
        return ({1'b0, x} < MAP_W6) && ({1'b0, y} < MAP_H6);
    endfunction

    function automatic logic [1:0] load_pattern(input logic [4:0] x, input logic [4:0] y);
        if (!in_map(x, y))
            return 2'd0;
        if (x == 5'd0 || x == X_LAST || y == 5'd0 || y == Y_LAST)
            return 2'd2;
        if (x[1:0] == 2'd2 && y[1:0] == 2'd2)
            return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] hit_result(input logic [1:0] t);
        case (t)
`ifdef MAP_BRICK_ARMOR_EN
            2'd1:    return 2'd3;
`else
            2'd1:    return 2'd0;
`endif
            2'd3:    return 2'd0;
            default: return t;
        endcase
    endfunction

    assign map_tile = in_map(map_rd_x, map_rd_y) ? tile_mem[{map_rd_y, map_rd_x}] : 2'd0;
    assign busy     = (state == ST_LOAD);

    // The previous cycle's grant masks its owner, who is still dropping req.
    logic [NREQ-1:0] elig;
    logic            win_vld;
    logic [RR_W-1:0] win_idx;
    logic [1:0]      win_op;
    logic [1:0]      win_wdata;
    logic [4:0]      win_x;
    logic [4:0]      win_y;
    int              idx;

    always_comb begin
        elig      = req & ~gnt;
        win_vld   = 1'b0;
        win_idx   = '0;
        win_op    = 2'd0;
        win_wdata = 2'd0;
        win_x     = 5'd0;
        win_y     = 5'd0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!win_vld && elig[idx]) begin
                win_vld   = 1'b1;
                win_idx   = RR_W'(idx);
                win_op    = req_op[2*idx +: 2];
                win_wdata = req_wdata[2*idx +: 2];
                win_x     = req_x[5*idx +: 5];
                win_y     = req_y[5*idx +: 5];
            end
        end
    end

    logic       win_in;
    logic [1:0] old_tile;
    logic [1:0] new_tile;
    logic       grant_fire;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [1:0] wr_data;

    // Out-of-range requests read as steel so movement blocks, and never write.
    always_comb begin
        win_in   = in_map(win_x, win_y);
        old_tile = win_in ? tile_mem[{win_y, win_x}] : 2'd2;
        case (win_op)
            OP_HIT:   new_tile = hit_result(old_tile);
            OP_WRITE: new_tile = win_wdata;
            default:  new_tile = old_tile;
        endcase
        grant_fire = (state == ST_IDLE) && win_vld;
        if (state == ST_LOAD) begin
            wr_en   = 1'b1;
            wr_addr = load_cnt;
            wr_data = load_pattern(load_cnt[4:0], load_cnt[9:5]);
        end else begin
            wr_en   = grant_fire && win_in && (win_op == OP_HIT || win_op == OP_WRITE);
            wr_addr = {win_y, win_x};
            wr_data = new_tile;
        end
    end

    always_ff @(posedge pclk) begin
        if (wr_en)
            tile_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_LOAD;
            load_cnt  <= 10'd0;
            rr_ptr    <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_tile  <= 2'd0;
            load_done <= 1'b0;
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            load_done <= 1'b0;
            if (grant_fire) begin
                gnt       <= NREQ'(1) << win_idx;
                rsp_valid <= 1'b1;
                rsp_tile  <= old_tile;
                rr_ptr    <= (win_idx == RR_W'(NREQ - 1)) ? '0 : win_idx + RR_W'(1);
            end
            case (state)
                ST_LOAD: begin
                    load_cnt <= load_cnt + 10'd1;
                    if (load_cnt == 10'd1023) begin
                        state     <= ST_IDLE;
                        load_done <= 1'b1;
                    end
                end
                default: begin
                    if (load_start) begin
                        state    <= ST_LOAD;
                        load_cnt <= 10'd0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_map_port_arbiter.sv
// Scoreboarded bench for map_port_arbiter: expected grants are queued at issue time and popped on rsp_valid.
module tb_map_port_arbiter;
    localparam int NREQ = 4;
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_HIT   = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    logic              pclk = 1'b0;
    logic              rstn = 1'b0;
    logic [4:0]        map_rd_x = '0;
    logic [4:0]        map_rd_y = '0;
    logic [1:0]        map_tile;
    logic [NREQ-1:0]   req = '0;
    logic [2*NREQ-1:0] req_op = '0;
    logic [5*NREQ-1:0] req_x = '0;
    logic [5*NREQ-1:0] req_y = '0;
    logic [2*NREQ-1:0] req_wdata = '0;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [1:0]        rsp_tile;
    logic              load_start = 1'b0;
    logic              busy;
    logic              load_done;

    map_port_arbiter #(.NREQ(NREQ), .MAP_W(25), .MAP_H(18)) dut (
        .pclk(pclk), .rstn(rstn),
        .map_rd_x(map_rd_x), .map_rd_y(map_rd_y), .map_tile(map_tile),
        .req(req), .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_wdata(req_wdata),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_tile(rsp_tile),
        .load_start(load_start), .busy(busy), .load_done(load_done)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         idx;
        logic [1:0] tile;
    } exp_t;
    exp_t sb[$];

    int n_cyc, ld_cyc, g1_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge pclk) begin : monitor
        exp_t e;
        if (rstn && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", 32'(gnt), 32'd0);
            end else begin
                e = sb.pop_front();
                check("gnt", 32'(gnt), 32'(1) << e.idx);
                check("rsp_tile", 32'(rsp_tile), 32'(e.tile));
            end
        end else if (rstn && gnt != '0) begin
            check("gnt_without_rsp", 32'(gnt), 32'd0);
        end
    end

    task automatic issue(input int i, input logic [1:0] op, input logic [4:0] x, input logic [4:0] y,
                         input logic [1:0] wd, input logic [1:0] exp_tile);
        req_op[2*i +: 2]    = op;
        req_x[5*i +: 5]     = x;
        req_y[5*i +: 5]     = y;
        req_wdata[2*i +: 2] = wd;
        req[i]              = 1'b1;
        sb.push_back('{i, exp_tile});
    endtask

    // Each requester drops req in its grant cycle.
    task automatic wait_grants(input int budget);
        n_cyc  = 0;
        ld_cyc = -1;
        g1_cyc = -1;
        while (req != '0 && n_cyc < budget) begin
            @(posedge pclk);
            #1;
            n_cyc++;
            if (load_done) ld_cyc = n_cyc;
            if (gnt[1]) g1_cyc = n_cyc;
            req = req & ~gnt;
        end
        if (req != '0) begin
            check("grant_timeout", 32'(req), 32'd0);
            req = '0;
        end
        @(negedge pclk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic peek(input string tag, input logic [4:0] x, input logic [4:0] y, input logic [1:0] exp);
        map_rd_x = x;
        map_rd_y = y;
        #1;
        check(tag, 32'(map_tile), 32'(exp));
    endtask

    task automatic release_and_load();
        int nb, nd;
        nb = 0;
        nd = 0;
        @(negedge pclk);
        rstn = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            if (busy) nb++;
            if (load_done) nd++;
            @(negedge pclk);
        end
        #1;
        check("busy_cycles", 32'(nb), 32'd1024);
        check("load_done_pulses", 32'(nd), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_tile"}, 32'(rsp_tile), 32'd0);
        check({tag, "_load_done"}, 32'(load_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and first level load
        repeat (2) @(posedge pclk);
        #1;
        check_reset_outputs("rst");
        release_and_load();
        peek("tile_0_5", 5'd0, 5'd5, 2'd2);
        peek("tile_2_2", 5'd2, 5'd2, 2'd1);
        peek("tile_3_3", 5'd3, 5'd3, 2'd0);
        peek("tile_24_17", 5'd24, 5'd17, 2'd2);
        peek("tile_25_0", 5'd25, 5'd0, 2'd0);
        peek("tile_6_6", 5'd6, 5'd6, 2'd1);

        // Four simultaneous reads: round-robin 0,1,2,3 on consecutive cycles
        for (int i = 0; i < NREQ; i++) issue(i, OP_READ, 5'd2, 5'd2, 2'd0, 2'd1);
        wait_grants(20);
        check("rr_cycles", 32'(n_cyc), 32'd4);

        // HIT on a brick; renderer sees the old value until the edge
        map_rd_x = 5'd6;
        map_rd_y = 5'd6;
        issue(0, OP_HIT, 5'd6, 5'd6, 2'd0, 2'd1);
        #1;
        check("render_before_hit", 32'(map_tile), 32'd1);
        wait_grants(20);
`ifdef MAP_BRICK_ARMOR_EN
        peek("tile_6_6_cracked", 5'd6, 5'd6, 2'd3);
        issue(0, OP_HIT, 5'd6, 5'd6, 2'd0, 2'd3);
        wait_grants(20);
`endif
        peek("tile_6_6_gone", 5'd6, 5'd6, 2'd0);
        issue(0, OP_READ, 5'd6, 5'd6, 2'd0, 2'd0);
        wait_grants(20);

        // Steel and out-of-range tiles
        issue(2, OP_HIT, 5'd0, 5'd0, 2'd0, 2'd2);
        wait_grants(20);
        issue(2, OP_READ, 5'd30, 5'd3, 2'd0, 2'd2);
        wait_grants(20);
        issue(2, OP_WRITE, 5'd25, 5'd0, 2'd1, 2'd2);
        wait_grants(20);
        peek("tile_0_0_steel", 5'd0, 5'd0, 2'd2);

        // WRITE then reload; request held through LOAD
        issue(3, OP_WRITE, 5'd5, 5'd5, 2'd2, 2'd0);
        wait_grants(20);
        peek("tile_5_5_written", 5'd5, 5'd5, 2'd2);
        load_start = 1'b1;
        issue(0, OP_READ, 5'd5, 5'd5, 2'd0, 2'd2);
        @(posedge pclk);
        #1;
        load_start = 1'b0;
        req = req & ~gnt;
        check("busy_after_load_start", 32'(busy), 32'd1);
        issue(1, OP_READ, 5'd2, 5'd2, 2'd0, 2'd1);
        wait_grants(1200);
        check("gnt1_after_load_done", 32'(g1_cyc - ld_cyc), 32'd1);
        peek("tile_5_5_restored", 5'd5, 5'd5, 2'd0);

        // Reset in the middle of LOAD
        load_start = 1'b1;
        @(posedge pclk);
        #1;
        load_start = 1'b0;
        repeat (100) @(posedge pclk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst_mid_load");
        release_and_load();

        // Reset while a grant is being presented
        issue(2, OP_READ, 5'd0, 5'd0, 2'd0, 2'd2);
        @(posedge pclk);
        #1;
        check("pre_reset_gnt", 32'(gnt), 32'd4);
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst_mid_grant");
        sb.delete();
        req = '0;
        release_and_load();
        issue(0, OP_READ, 5'd2, 5'd2, 2'd0, 2'd1);
        wait_grants(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
